led_matrix_scanner: RTL and testbench



---
 rtl/led_matrix_pkg.sv | 11 +
 rtl/led_matrix_scanner_if.sv | 14 +
 rtl/led_frame_buffer.sv | 45 ++++
 rtl/led_matrix_scanner.sv | 147 ++++++++++++++
 tb/tb_led_matrix_scanner.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/led_matrix_pkg.sv
// Shared types and constants for the LED matrix scanner.
package led_matrix_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  localparam int BRIGHT_W  = 3;
  localparam int PWM_SHIFT = 3;
endpackage

// File: rtl/led_matrix_scanner_if.sv
// Frame handoff from game logic to the scanner.
interface led_matrix_scanner_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8
);
  // A frame transfers on a clk edge where frame_valid_i && frame_ready_o are both high;
  // the source holds frame_valid_i and frame_i stable until that edge.
  logic [ROWS*COLS-1:0] frame_i;
  logic                 frame_valid_i;
  logic                 frame_ready_o;

  modport master (output frame_i, frame_valid_i, input frame_ready_o);
  modport slave  (input frame_i, frame_valid_i, output frame_ready_o);
endinterface

// File: rtl/led_frame_buffer.sv
// Front/back frame storage; a swap request promotes a pending back frame.
module led_frame_buffer
  import led_matrix_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  led_matrix_scanner_if.slave  frm,
  input  logic                 i_swap,
  output logic [ROWS*COLS-1:0] o_disp,
  output logic                 o_front_valid,
  output logic                 o_pending
);
  logic [ROWS*COLS-1:0] r_front;
  logic [ROWS*COLS-1:0] r_back;
  logic                 r_pending;
  logic                 r_front_valid;

  // Capture needs !r_pending and swap needs r_pending, so they never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_front       <= '0;
      r_back        <= '0;
      r_pending     <= 1'b0;
      r_front_valid <= 1'b0;
    end else begin
      if (frm.frame_valid_i && !r_pending) begin
        r_back    <= frm.frame_i;
        r_pending <= 1'b1;
      end
      if (i_swap && r_pending) begin
        r_front       <= r_back;
        r_pending     <= 1'b0;
        r_front_valid <= 1'b1;
      end
    end
  end

  assign frm.frame_ready_o = !r_pending;
  assign o_disp            = (i_swap && r_pending) ? r_back : r_front;
  assign o_front_valid     = r_front_valid;
  assign o_pending         = r_pending;
endmodule

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed LED matrix scan driver with double-buffered, tear-free frames.
// Define LED_MATRIX_PWM_EN to gate columns by a per-frame brightness level.
module led_matrix_scanner
  import led_matrix_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int DWELL = 1250,
  parameter int BLANK = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  led_matrix_scanner_if.slave     frm,
  input  logic [BRIGHT_W-1:0]     bright_i,
  output logic [ROWS-1:0]         row_o,
  output logic [COLS-1:0]         col_o,
  output logic [$clog2(ROWS)-1:0] row_idx_o,
  output logic                    frame_done_o,
  output state_t                  dbg_state_o
);
  localparam int RW      = $clog2(ROWS);
  localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

  state_t               r_state, w_state_nxt;
  logic [RW-1:0]        r_row, w_row_nxt;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  logic [ROWS-1:0]      r_row_o, w_row_o_nxt;
  logic [COLS-1:0]      r_col_o, w_col_o_nxt;
  logic                 r_done;
  logic                 w_row_end, w_boundary, w_start, w_gate;
  logic                 w_front_valid, w_pending;
  logic [ROWS*COLS-1:0] w_disp;

  assign w_start    = (r_state == ST_IDLE) && en_i && (w_front_valid || w_pending);
  assign w_boundary = w_row_end && (r_row == ROW_LAST);

  led_frame_buffer #(.ROWS(ROWS), .COLS(COLS)) u_buf (
    .clk           (clk),
    .rst_n         (rst_n),
    .frm           (frm),
    .i_swap        (w_start || w_boundary),
    .o_disp        (w_disp),
    .o_front_valid (w_front_valid),
    .o_pending     (w_pending)
  );

`ifdef LED_MATRIX_PWM_EN
  localparam int OW = $clog2(DWELL) + 4;
  localparam int GW = (OW > CW) ? OW : CW;
  logic [OW-1:0] r_on_cyc, w_on_cyc_smp, w_on_cyc_nxt;

  assign w_on_cyc_smp = ((OW'(bright_i) + OW'(1)) * OW'(DWELL)) >> PWM_SHIFT;
  assign w_on_cyc_nxt = (w_start || w_boundary) ? w_on_cyc_smp : r_on_cyc;
  assign w_gate       = GW'(w_cnt_nxt) < GW'(w_on_cyc_nxt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_on_cyc <= '0;
    else        r_on_cyc <= w_on_cyc_nxt;
  end
`else
  logic w_unused_bright;
  assign w_unused_bright = ^bright_i;
  assign w_gate          = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_row   <= '0;
      r_cnt   <= '0;
      r_row_o <= '0;
      r_col_o <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_cnt   <= w_cnt_nxt;
      r_row_o <= w_row_o_nxt;
      r_col_o <= w_col_o_nxt;
      r_done  <= w_boundary;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_cnt_nxt   = r_cnt;
    w_row_end   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_SCAN;
          w_row_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      end
      ST_SCAN: begin
        if (r_cnt == DWELL_LAST) begin
          w_cnt_nxt = '0;
          if (BLANK > 0) w_state_nxt = ST_BLANK;
          else           w_row_end   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_cnt_nxt = '0;
          w_row_end = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // A disable only takes effect once the last row of the frame has finished.
    if (w_row_end) begin
      if (r_row == ROW_LAST) begin
        w_row_nxt   = '0;
        w_state_nxt = en_i ? ST_SCAN : ST_IDLE;
      end else begin
        w_row_nxt   = r_row + RW'(1);
        w_state_nxt = ST_SCAN;
      end
    end
  end

  always_comb begin
    w_row_o_nxt = '0;
    w_col_o_nxt = '0;
    if (w_state_nxt == ST_SCAN) begin
      w_row_o_nxt[w_row_nxt] = 1'b1;
      if (w_gate) w_col_o_nxt = w_disp[int'(w_row_nxt)*COLS +: COLS];
    end
  end

  assign row_o        = r_row_o;
  assign col_o        = r_col_o;
  assign row_idx_o    = r_row;
  assign frame_done_o = r_done;
  assign dbg_state_o  = r_state;
endmodule

// File: tb/tb_led_matrix_scanner.sv
// Bench for led_matrix_scanner at ROWS=4, COLS=4, DWELL=8, BLANK=2.
module tb_led_matrix_scanner;
  import led_matrix_pkg::*;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int DWELL  = 8;
  localparam int BLANK  = 2;
  localparam int PERIOD = ROWS * (DWELL + BLANK);
`ifdef LED_MATRIX_PWM_EN
  localparam int BRIGHT = 1;
  localparam int ON_CYC = ((BRIGHT + 1) * DWELL) >> 3;
`else
  localparam int ON_CYC = DWELL;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_i = 1'b0;
  logic [2:0]  bright_i = 3'd0;
  logic [ROWS-1:0] row_o;
  logic [COLS-1:0] col_o;
  logic [1:0]  row_idx_o;
  logic        frame_done_o;
  state_t      dbg_state;

  led_matrix_scanner_if #(.ROWS(ROWS), .COLS(COLS)) frm_if ();

  led_matrix_scanner #(.ROWS(ROWS), .COLS(COLS), .DWELL(DWELL), .BLANK(BLANK)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (en_i),
    .frm          (frm_if),
    .bright_i     (bright_i),
    .row_o        (row_o),
    .col_o        (col_o),
    .row_idx_o    (row_idx_o),
    .frame_done_o (frame_done_o),
    .dbg_state_o  (dbg_state)
  );

  // clock and cycle count
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // scoreboard: rows expected per frame, and frames handed to the DUT
  logic [5:0]  exp_q[$];
  int          cap_cyc_q[$];
  logic [15:0] cap_dat_q[$];

  logic [15:0]     m_front, m_back;
  bit              m_pending;
  int              m_cap;
  logic [ROWS-1:0] prev_row;
  int              seg_len, gap_len, last_seg_row, cur_row;
  bit              seen_seg;
  logic [COLS-1:0] cur_col;
  logic [5:0]      e;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete(); cap_cyc_q.delete(); cap_dat_q.delete();
      m_front = '0; m_back = '0; m_pending = 0; m_cap = 0;
      prev_row = '0; seg_len = 0; gap_len = 0; last_seg_row = 0; cur_row = 0;
      seen_seg = 0; cur_col = '0;
    end else begin
      if (row_o != prev_row) begin
        if (prev_row != '0) begin
          check("dwell_len", seg_len, DWELL);
          gap_len = 0; seen_seg = 1; last_seg_row = cur_row;
        end
        if (row_o != '0) begin
          if (seen_seg && last_seg_row != ROWS - 1) check("blank_len", gap_len, BLANK);
          // a frame started: a frame pending from an earlier edge is swapped in
          if (row_o == ROWS'(1)) begin
            if (m_pending && m_cap < cyc) begin
              m_front = m_back; m_pending = 0;
            end
            for (int r = 0; r < ROWS; r++) exp_q.push_back({2'(r), m_front[r*COLS +: COLS]});
          end
          if (exp_q.size() == 0) begin
            check("row_unexp", row_o, 0);
            cur_row = 0; cur_col = '0;
          end else begin
            e = exp_q.pop_front();
            cur_row = int'(e[5:4]); cur_col = e[3:0];
            check("row_sel", row_o, ROWS'(1) << cur_row);
            check("row_idx", row_idx_o, cur_row);
          end
          seg_len = 0;
        end
      end
      if (row_o != '0) begin
        check("col", col_o, (seg_len < ON_CYC) ? cur_col : '0);
        seg_len++;
      end else begin
        gap_len++;
      end
      prev_row = row_o;
      while (cap_cyc_q.size() != 0 && cap_cyc_q[0] <= cyc) begin
        m_back = cap_dat_q.pop_front(); m_cap = cap_cyc_q.pop_front(); m_pending = 1;
      end
      check("ready", frm_if.frame_ready_o, !m_pending);
    end
  end

  // driver: present a frame no earlier than edge cap_at, hold until accepted
  task automatic send_frame(input logic [15:0] d, input int cap_at);
    int n;
    n = 0;
    @(negedge clk);
    while (cyc < cap_at - 1 && n < 1000) begin @(negedge clk); n++; end
    #1;
`ifndef LED_MATRIX_PWM_EN
    bright_i = 3'($urandom_range(0, 7));
`endif
    frm_if.frame_i = d;
    frm_if.frame_valid_i = 1'b1;
    n = 0;
    while (!frm_if.frame_ready_o && n < 500) begin @(negedge clk); #1; n++; end
    check("send_ready", frm_if.frame_ready_o, 1'b1);
    if (frm_if.frame_ready_o) begin
      cap_cyc_q.push_back(cyc + 1);
      cap_dat_q.push_back(d);
    end
    @(posedge clk); #1;
    frm_if.frame_valid_i = 1'b0;
    frm_if.frame_i = 16'($urandom);
  endtask

  task automatic wait_done(output int at);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_done_o && n < 200);
    check("done_seen", frame_done_o, 1'b1);
    at = cyc;
  endtask

  task automatic wait_row(input int r);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (row_o != ROWS'(1 << r) && n < 200);
    check("row_seen", row_o, ROWS'(1 << r));
  endtask

  initial begin
    int e1, e2, e3;
    frm_if.frame_valid_i = 1'b0;
    frm_if.frame_i = '0;
`ifdef LED_MATRIX_PWM_EN
    bright_i = 3'(BRIGHT);
`endif
    repeat (3) @(negedge clk);
    check("rst_row", row_o, 0);
    check("rst_col", col_o, 0);
    check("rst_idx", row_idx_o, 0);
    check("rst_done", frame_done_o, 0);
    check("rst_ready", frm_if.frame_ready_o, 1);
    check("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;

    // enabled with nothing loaded stays dark
    en_i = 1'b1;
    repeat (20) @(negedge clk);
    check("empty_row", row_o, 0);
    check("empty_col", col_o, 0);
    check("empty_ready", frm_if.frame_ready_o, 1);

    // single frame, period and pulse width
    send_frame(16'h8421, 0);
    wait_done(e1);
    @(negedge clk);
    check("done_pulse", frame_done_o, 0);
    wait_done(e2);
    check("done_period", e2 - e1, PERIOD);

    // load mid-frame, second load held off until the swap
    wait_row(2);
    send_frame(16'h5A3C, 0);
    send_frame(16'($urandom), 0);
    repeat (3) wait_done(e1);

    // capture on the boundary edge waits one more frame
    wait_done(e1);
    send_frame(16'hC3A5, e1 + PERIOD);
    wait_done(e2);
    wait_done(e3);
    check("bnd_period", e3 - e2, PERIOD);

    // disable at row 1: frame completes, then idle; re-enable restarts at row 0
    wait_row(1);
    en_i = 1'b0;
    wait_done(e1);
    repeat (10) begin
      @(negedge clk);
      check("off_row", row_o, 0);
      check("off_col", col_o, 0);
    end
    check("off_state", dbg_state, ST_IDLE);
    check("off_queue", exp_q.size(), 0);
    en_i = 1'b1;
    @(negedge clk);
    check("restart_row", row_o, 4'b0001);
    wait_done(e1);

    // random frames
    repeat (2) begin
      send_frame(16'($urandom), 0);
      wait_done(e1);
      wait_done(e1);
    end

    // asynchronous reset mid-row clears outputs and both buffers
    wait_row(2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_row", row_o, 0);
    check("arst_col", col_o, 0);
    check("arst_idx", row_idx_o, 0);
    check("arst_done", frame_done_o, 0);
    check("arst_ready", frm_if.frame_ready_o, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_row", row_o, 0);
    check("post_rst_col", col_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
